axis_udp_filter_arb: RTL and testbench

//  Frame-level round-robin arbiter that shares one axis_udp_filter instance between NUM_PORTS AXI-Stream ingress

---
 rtl/axis_udp_filter_arb.sv | 99 +++++++++
 tb/tb_axis_udp_filter_arb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_udp_filter_arb.sv
// axis_udp_filter_arb: frame-level round-robin arbiter feeding one AXI-Stream filter through a 2-entry skid stage
module axis_udp_filter_arb #(
  parameter int NUM_PORTS = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                         clk_i,
  input  logic                         s_rst_n_i,
  input  logic [NUM_PORTS-1:0]         s_axis_tvalid,
  input  logic [NUM_PORTS*64-1:0]      s_axis_tdata,
  input  logic [NUM_PORTS*8-1:0]       s_axis_tstrb,
  input  logic [NUM_PORTS-1:0]         s_axis_tlast,
  output logic [NUM_PORTS-1:0]         s_axis_tready,
  output logic                         m_axis_tvalid,
  output logic [63:0]                  m_axis_tdata,
  output logic [7:0]                   m_axis_tstrb,
  output logic                         m_axis_tlast,
  input  logic                         m_axis_tready,
  input  logic                         en_i,
  output logic                         busy_o,
  output logic [$clog2(NUM_PORTS)-1:0] grant_o,
  output logic [CNT_WIDTH-1:0]         frame_cnt_o
);
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int GW = $clog2(NUM_PORTS);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] grant_q, grant_d, pick;
  logic found;
  logic [1:0] cnt_q;
  logic [DW-1:0] hd_data_q, tl_data_q, in_data;
  logic [SW-1:0] hd_strb_q, tl_strb_q, in_strb;
  logic hd_last_q, tl_last_q, in_last, wr, rd, not_full;
  logic [CNT_WIDTH-1:0] frame_cnt_q;
  assign in_data  = s_axis_tdata[int'(grant_q)*DW +: DW];
  assign in_strb  = s_axis_tstrb[int'(grant_q)*SW +: SW];
  assign in_last  = s_axis_tlast[grant_q];
  assign not_full = cnt_q != 2'd2;
  assign wr = state_q == XFER && not_full && s_axis_tvalid[grant_q];
  assign rd = cnt_q != 2'd0 && m_axis_tready;
  assign m_axis_tvalid = cnt_q != 2'd0;
  assign m_axis_tdata  = hd_data_q;
  assign m_axis_tstrb  = hd_strb_q;
  assign m_axis_tlast  = hd_last_q;
  assign busy_o      = state_q == XFER;
  assign grant_o     = grant_q;
  assign frame_cnt_o = frame_cnt_q;
  always_comb begin
    s_axis_tready = '0;
    s_axis_tready[grant_q] = state_q == XFER && not_full;
  end
  // Scan starts one past the last grant so every requester gets a turn
  always_comb begin
    pick  = grant_q;
    found = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++)
      if (!found && s_axis_tvalid[GW'((int'(grant_q) + i) % NUM_PORTS)]) begin
        found = 1'b1;
        pick  = GW'((int'(grant_q) + i) % NUM_PORTS);
      end
  end
  always_comb begin
    state_d = (state_q == IDLE) ? ((en_i && found) ? XFER : IDLE) : ((wr && in_last) ? IDLE : XFER);
    grant_d = (state_q == IDLE && en_i && found) ? pick : grant_q;
  end
  always_ff @(posedge clk_i) begin
    if (!s_rst_n_i) begin
      state_q     <= IDLE;
      grant_q     <= GW'(NUM_PORTS - 1);
      cnt_q       <= 2'd0;
      hd_data_q   <= '0;
      hd_strb_q   <= '0;
      hd_last_q   <= 1'b0;
      tl_data_q   <= '0;
      tl_strb_q   <= '0;
      tl_last_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_q + {1'b0, wr} - {1'b0, rd};
      if (rd && hd_last_q) frame_cnt_q <= frame_cnt_q + CNT_WIDTH'(1);
      if (wr && (cnt_q == 2'd0 || (cnt_q == 2'd1 && rd))) begin
        hd_data_q <= in_data;
        hd_strb_q <= in_strb;
        hd_last_q <= in_last;
      end else if (rd && cnt_q == 2'd2) begin
        hd_data_q <= tl_data_q;
        hd_strb_q <= tl_strb_q;
        hd_last_q <= tl_last_q;
      end
      if (wr && cnt_q == 2'd1 && !rd) begin
        tl_data_q <= in_data;
        tl_strb_q <= in_strb;
        tl_last_q <= in_last;
      end
    end
  end
endmodule

// File: tb/tb_axis_udp_filter_arb.sv
// tb_axis_udp_filter_arb: directed bench for the round-robin frame arbiter and its skid stage
module tb_axis_udp_filter_arb;
  typedef struct packed {logic last; logic [63:0] data;} beat_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, en, m_tready, m_tvalid, m_tlast, busy, grant;
  logic [1:0] tvalid, tlast, tready, hold;
  logic [127:0] tdata;
  logic [15:0] tstrb;
  logic [63:0] m_tdata;
  logic [7:0] m_tstrb;
  logic [3:0] fcnt;
  beat_t srcq0[$], srcq1[$], outq[$];
  int checks = 0, failures = 0;
  logic stall_prev = 1'b0;
  logic [64:0] stall_data;
  axis_udp_filter_arb #(.NUM_PORTS(2), .CNT_WIDTH(4)) dut (
    .clk_i(clk), .s_rst_n_i(rst_n),
    .s_axis_tvalid(tvalid), .s_axis_tdata(tdata), .s_axis_tstrb(tstrb),
    .s_axis_tlast(tlast), .s_axis_tready(tready),
    .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .en_i(en), .busy_o(busy), .grant_o(grant), .frame_cnt_o(fcnt)
  );
  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive();
    tvalid[0] = srcq0.size() > 0 && !hold[0];
    tdata[63:0] = srcq0.size() > 0 ? srcq0[0].data : 64'h0;
    tlast[0] = srcq0.size() > 0 ? srcq0[0].last : 1'b0;
    tvalid[1] = srcq1.size() > 0 && !hold[1];
    tdata[127:64] = srcq1.size() > 0 ? srcq1[0].data : 64'h0;
    tlast[1] = srcq1.size() > 0 ? srcq1[0].last : 1'b0;
    tstrb = '1;
  endtask
  task automatic tick();
    logic [1:0] acc;
    @(negedge clk);
    acc = tvalid & tready & {2{rst_n}};
    if (rst_n && m_tvalid && m_tready) outq.push_back({m_tlast, m_tdata});
    if (stall_prev) begin
      chk("stall_valid", 65'(m_tvalid), 65'(1));
      chk("stall_data", {m_tlast, m_tdata}, stall_data);
    end
    stall_prev = rst_n && m_tvalid && !m_tready;
    stall_data = {m_tlast, m_tdata};
    @(posedge clk);
    #1;
    if (acc[0]) void'(srcq0.pop_front());
    if (acc[1]) void'(srcq1.pop_front());
    drive();
  endtask
  task automatic load(input int p, input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++)
      if (p == 0) srcq0.push_back({1'(i == n - 1), base + 64'(i)});
      else srcq1.push_back({1'(i == n - 1), base + 64'(i)});
    drive();
  endtask
  task automatic run_until_out(input string tag, input int n, input int budget);
    int c = 0;
    while (outq.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk(tag, 65'(outq.size() >= n), 65'(1));
  endtask
  task automatic expect_frame(input string tag, input int start, input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++)
      chk(tag, outq[start + i], {1'(i == n - 1), base + 64'(i)});
  endtask
  initial begin
    logic [3:0] pat;
    int c;
    rst_n = 1'b0; en = 1'b1; m_tready = 1'b1; hold = 2'b00;
    tvalid = '0; tdata = '0; tstrb = '0; tlast = '0;
    for (int f = 0; f < 4; f++) begin
      load(0, 64'hA0 + 64'(f) * 64'h100, 4);
      load(1, 64'hB0 + 64'(f) * 64'h100, 4);
    end
    repeat (4) tick();
    chk("rst_tready", 65'(tready), 65'(0));
    chk("rst_mvalid", 65'(m_tvalid), 65'(0));
    chk("rst_fcnt", 65'(fcnt), 65'(0));
    chk("rst_busy", 65'(busy), 65'(0));
    chk("rst_grant", 65'(grant), 65'(1));
    rst_n = 1'b1;
    run_until_out("t2_done", 32, 300);
    for (int k = 0; k < 8; k++)
      expect_frame("t2_beat", k * 4, ((k % 2) ? 64'hB0 : 64'hA0) + 64'(k / 2) * 64'h100, 4);
    chk("t2_fcnt", 65'(fcnt), 65'(8));
    chk("t2_grant", 65'(grant), 65'(1));
    chk("t2_tstrb", 65'(m_tstrb), 65'(8'hFF));
    outq.delete();
    load(0, 64'hC0, 6);
    pat = 4'b1001;
    c = 0;
    while (outq.size() < 6 && c < 60) begin
      m_tready = pat[c % 4];
      tick();
      c++;
    end
    chk("t3a_done", 65'(outq.size() >= 6), 65'(1));
    m_tready = 1'b1;
    repeat (3) tick();
    chk("t3a_count", 65'(outq.size()), 65'(6));
    expect_frame("t3a_beat", 0, 64'hC0, 6);
    chk("t3a_fcnt", 65'(fcnt), 65'(9));
    outq.delete();
    m_tready = 1'b0;
    load(1, 64'hD0, 6);
    repeat (6) tick();
    chk("t3b_accepted", 65'(srcq1.size()), 65'(4));
    chk("t3b_tready", 65'(tready), 65'(0));
    chk("t3b_mvalid", 65'(m_tvalid), 65'(1));
    chk("t3b_head", 65'(m_tdata), 65'(64'hD0));
    m_tready = 1'b1;
    run_until_out("t3b_done", 6, 60);
    expect_frame("t3b_beat", 0, 64'hD0, 6);
    chk("t3b_fcnt", 65'(fcnt), 65'(10));
    outq.delete();
    load(0, 64'hE0, 4);
    load(1, 64'hF0, 2);
    c = 0;
    while (srcq0.size() > 2 && c < 20) begin
      tick();
      c++;
    end
    chk("t4_two_beats", 65'(srcq0.size()), 65'(2));
    hold[0] = 1'b1;
    drive();
    repeat (5) begin
      tick();
      chk("t4_grant", 65'(grant), 65'(0));
      chk("t4_tready1", 65'(tready[1]), 65'(0));
      chk("t4_busy", 65'(busy), 65'(1));
    end
    hold[0] = 1'b0;
    drive();
    c = 0;
    while (srcq0.size() > 0 && c < 20) begin
      chk("t4_tready1_tail", 65'(tready[1]), 65'(0));
      tick();
      c++;
    end
    run_until_out("t4_done", 6, 40);
    expect_frame("t4_p0", 0, 64'hE0, 4);
    expect_frame("t4_p1", 4, 64'hF0, 2);
    chk("t4_fcnt", 65'(fcnt), 65'(12));
    outq.delete();
    load(0, 64'h50, 4);
    load(1, 64'h60, 2);
    c = 0;
    while (srcq0.size() > 3 && c < 20) begin
      tick();
      c++;
    end
    en = 1'b0;
    c = 0;
    while (srcq0.size() > 0 && c < 20) begin
      tick();
      c++;
    end
    repeat (5) tick();
    chk("t5_frame_done", 65'(outq.size()), 65'(4));
    chk("t5_busy", 65'(busy), 65'(0));
    chk("t5_p1_waiting", 65'(srcq1.size()), 65'(2));
    chk("t5_tready1", 65'(tready[1]), 65'(0));
    chk("t5_grant_hold", 65'(grant), 65'(0));
    en = 1'b1;
    tick();
    chk("t5_busy_regrant", 65'(busy), 65'(1));
    chk("t5_grant_regrant", 65'(grant), 65'(1));
    run_until_out("t5_done", 6, 40);
    expect_frame("t5_p0", 0, 64'h50, 4);
    expect_frame("t5_p1", 4, 64'h60, 2);
    chk("t5_fcnt", 65'(fcnt), 65'(14));
    outq.delete();
    load(0, 64'h70, 5);
    c = 0;
    while (srcq0.size() > 3 && c < 20) begin
      tick();
      c++;
    end
    chk("t6_two_beats", 65'(srcq0.size()), 65'(3));
    rst_n = 1'b0;
    srcq0.delete();
    srcq1.delete();
    drive();
    tick();
    chk("t6_mvalid", 65'(m_tvalid), 65'(0));
    chk("t6_fcnt_rst", 65'(fcnt), 65'(0));
    chk("t6_busy", 65'(busy), 65'(0));
    chk("t6_grant", 65'(grant), 65'(1));
    chk("t6_tready", 65'(tready), 65'(0));
    rst_n = 1'b1;
    outq.delete();
    repeat (3) tick();
    chk("t6_no_tail", 65'(outq.size()), 65'(0));
    for (int f = 0; f < 17; f++) srcq0.push_back({1'b1, 64'h200 + 64'(f)});
    drive();
    run_until_out("t6_done", 17, 150);
    chk("t6_first", outq[0], {1'b1, 64'h200});
    chk("t6_last", outq[16], {1'b1, 64'h210});
    chk("t6_fcnt_wrap", 65'(fcnt), 65'(1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
